// File: rtl/msl_tx_arbiter_if.sv
// Requester and frame-sender signals shared by the MSL transmit arbiter.
// master = arbiter side, slave = requesters plus sender.
interface msl_tx_arbiter_if #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_NUM_REQ    = 4
);
   localparam int L_ID_W = $clog2(P_NUM_REQ);

   logic [P_NUM_REQ-1:0]              i_req_valid;
   logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data;
   logic [P_NUM_REQ-1:0]              o_req_ready;
   logic                              o_tx_start;
   logic [P_DATA_WIDTH-1:0]           o_tx_data;
   logic [L_ID_W-1:0]                 o_tx_id;
   logic                              o_tx_abort;
   logic                              i_tx_busy;
   logic                              i_tx_done;

   modport master (
      input  i_req_valid, i_req_data, i_tx_busy, i_tx_done,
      output o_req_ready, o_tx_start, o_tx_data, o_tx_id, o_tx_abort
   );

   modport slave (
      output i_req_valid, i_req_data, i_tx_busy, i_tx_done,
      input  o_req_ready, o_tx_start, o_tx_data, o_tx_id, o_tx_abort
   );
endinterface

// File: rtl/msl_tx_arbiter.sv
// Round-robin scheduler sharing one MSL frame sender; valid seen idle -> ready +1 -> start +2.
// One frame in flight; requesters are held off until sender done or watchdog abort.
module msl_tx_arbiter #(
   parameter int P_DATA_WIDTH  = 8,
   parameter int P_NUM_REQ     = 4,
   parameter int P_TIMEOUT_CYC = 8_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   msl_tx_arbiter_if.master      bus,
   output logic                  o_busy,
   output logic                  o_timeout,
   output logic [15:0]           o_frame_cnt
);
   localparam int L_ID_W  = $clog2(P_NUM_REQ);
   localparam int L_CNT_W = $clog2(P_TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RECOVER = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [L_ID_W-1:0]       id_q, id_d;
   logic [L_ID_W-1:0]       last_q, last_d;
   logic [P_DATA_WIDTH-1:0] data_q, data_d;
   logic [L_CNT_W-1:0]      cnt_q, cnt_d;
   logic [15:0]             frame_q, frame_d;
   logic                    start_q, start_d;
   logic                    abort_q, abort_d;

   logic                    win_vld;
   logic [L_ID_W-1:0]       win_id;
   logic [L_ID_W-1:0]       scan_id;
   logic [P_DATA_WIDTH-1:0] req_word [P_NUM_REQ];

   for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_word
      assign req_word[k] = bus.i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
   end

   // Scan starts one past the last served requester so every requester gets a turn.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      scan_id = '0;
      for (int i = 1; i <= P_NUM_REQ; i++) begin
         scan_id = L_ID_W'((int'(last_q) + i) % P_NUM_REQ);
         if (!win_vld && bus.i_req_valid[scan_id]) begin
            win_vld = 1'b1;
            win_id  = scan_id;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      last_d  = last_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      start_d = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_enable && win_vld) begin
               id_d    = win_id;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // A requester that drops valid here forfeits the slot without advancing the pointer.
            if (bus.i_req_valid[id_q]) begin
               data_d  = req_word[id_q];
               cnt_d   = '0;
               start_d = 1'b1;
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + L_CNT_W'(1);
            if (bus.i_tx_done) begin
               last_d  = id_q;
               frame_d = frame_q + 16'd1;
               state_d = S_IDLE;
            end else if (cnt_q == L_CNT_W'(P_TIMEOUT_CYC - 1)) begin
               last_d  = id_q;
               abort_d = 1'b1;
               state_d = S_RECOVER;
            end
         end
         S_RECOVER: begin
            if (!bus.i_tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         last_q  <= L_ID_W'(P_NUM_REQ - 1);
         data_q  <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         start_q <= start_d;
         abort_q <= abort_d;
      end
   end

   assign bus.o_req_ready = (state_q == S_GRANT) ? (P_NUM_REQ'(1) << id_q) : '0;
   assign bus.o_tx_start  = start_q;
   assign bus.o_tx_data   = data_q;
   assign bus.o_tx_id     = id_q;
   assign bus.o_tx_abort  = abort_q;
   assign o_timeout       = abort_q;
   assign o_busy          = (state_q != S_IDLE);
   assign o_frame_cnt     = frame_q;
endmodule

// File: tb/tb_msl_tx_arbiter.sv
// Randomized bench for msl_tx_arbiter: acts as requesters and frame sender, checked against a
// transaction-level round-robin model (pending set, last served id, frame count).
module tb_msl_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 100;

   localparam int M_DONE  = 0;
   localparam int M_TERM  = 1;
   localparam int M_TMO   = 2;
   localparam int M_DROP  = 3;
   localparam int M_RST   = 4;
   localparam int M_ENOFF = 5;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b0;
   logic        busy_o;
   logic        timeout_o;
   logic [15:0] fcnt_o;

   msl_tx_arbiter_if #(.P_DATA_WIDTH(DW), .P_NUM_REQ(NR)) bus ();

   msl_tx_arbiter #(.P_DATA_WIDTH(DW), .P_NUM_REQ(NR), .P_TIMEOUT_CYC(TO)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (enable),
      .bus         (bus.master),
      .o_busy      (busy_o),
      .o_timeout   (timeout_o),
      .o_frame_cnt (fcnt_o)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [NR-1:0] pend;
   logic [DW-1:0] pdata [NR];
   int          last;
   logic [15:0] exp_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: first pending requester after the last one served.
   function automatic int rr_pick(input int lst, input logic [NR-1:0] m);
      for (int d = 1; d <= NR; d++) begin
         if (m[(lst + d) % NR]) return (lst + d) % NR;
      end
      return -1;
   endfunction

   task automatic add_req(input int k);
      if (!pend[k]) begin
         pend[k]  = 1'b1;
         pdata[k] = DW'($urandom);
      end
   endtask

   task automatic drive_req();
      bus.i_req_valid = pend;
      for (int k = 0; k < NR; k++) begin
         bus.i_req_data[k*DW +: DW] = pend[k] ? pdata[k] : DW'($urandom);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(bus.o_req_ready), 32'd0);
      check({tag, "_start"}, 32'(bus.o_tx_start), 32'd0);
      check({tag, "_abort"}, 32'(bus.o_tx_abort), 32'd0);
      check({tag, "_tmo"},   32'(timeout_o), 32'd0);
      check({tag, "_data"},  32'(bus.o_tx_data), 32'd0);
      check({tag, "_id"},    32'(bus.o_tx_id), 32'd0);
      check({tag, "_busy"},  32'(busy_o), 32'd0);
      check({tag, "_cnt"},   32'(fcnt_o), 32'd0);
   endtask

   initial begin
      int mode;
      int w;
      int n;
      int len;
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      bus.i_tx_busy   = 1'b0;
      bus.i_tx_done   = 1'b0;
      pend    = '0;
      last    = NR - 1;
      exp_cnt = 16'd0;
      for (int k = 0; k < NR; k++) pdata[k] = '0;

      #12;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;

      for (int f = 0; f < 60; f++) begin
         if (f < 6) begin
            for (int k = 0; k < NR; k++) add_req(k);
         end else if (f < 9) begin
            pend = pend & 4'b1001;
            add_req(0);
            add_req(3);
         end else if (pend == '0 || $urandom_range(0, 2) == 0) begin
            add_req($urandom_range(0, NR - 1));
            if ($urandom_range(0, 1) == 1) add_req($urandom_range(0, NR - 1));
         end
         drive_req();

         case (f)
            9:       mode = M_TMO;
            10:      mode = M_TERM;
            11:      mode = M_DROP;
            12:      mode = M_RST;
            13:      mode = M_ENOFF;
            default: begin
               if (f < 9) mode = M_DONE;
               else begin
                  case ($urandom_range(0, 7))
                     0, 1, 2: mode = M_DONE;
                     3:       mode = M_TERM;
                     4:       mode = M_TMO;
                     5:       mode = M_DROP;
                     6:       mode = M_RST;
                     default: mode = M_ENOFF;
                  endcase
               end
            end
         endcase

         w = rr_pick(last, pend);
         tick();
         check("grant_ready", 32'(bus.o_req_ready), 32'd1 << w);
         check("grant_busy", 32'(busy_o), 32'd1);
         check("grant_nostart", 32'(bus.o_tx_start), 32'd0);

         if (mode == M_DROP) begin
            pend[w] = 1'b0;
            drive_req();
            tick();
            check("drop_idle", 32'(busy_o), 32'd0);
            check("drop_nostart", 32'(bus.o_tx_start), 32'd0);
            add_req(w);
            drive_req();
            continue;
         end

         bus.i_tx_done = 1'($urandom_range(0, 1));
         tick();
         bus.i_tx_done = 1'b0;
         check("start", 32'(bus.o_tx_start), 32'd1);
         check("tx_data", 32'(bus.o_tx_data), 32'(pdata[w]));
         check("tx_id", 32'(bus.o_tx_id), 32'(w));
         check("ready_cleared", 32'(bus.o_req_ready), 32'd0);
         pend[w] = 1'b0;
         drive_req();
         bus.i_tx_busy = 1'b1;
         if (mode == M_ENOFF) enable = 1'b0;

         if (mode == M_RST) begin
            repeat ($urandom_range(1, 20)) tick();
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            exp_cnt = 16'd0;
            last    = NR - 1;
            bus.i_tx_busy = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            add_req(0);
            drive_req();
         end else if (mode == M_TMO) begin
            n = 0;
            while (bus.o_tx_abort !== 1'b1 && n < TO + 20) begin
               tick();
               n++;
               if (n == 1) check("start_once", 32'(bus.o_tx_start), 32'd0);
            end
            check("abort_time", 32'(n), 32'(TO));
            check("timeout_pulse", 32'(timeout_o), 32'd1);
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
               tick();
               if (j == 0) check("abort_1cyc", 32'(bus.o_tx_abort), 32'd0);
            end
            check("recover_hold", 32'(busy_o), 32'd1);
            bus.i_tx_busy = 1'b0;
            tick();
            check("recover_idle", 32'(busy_o), 32'd0);
            check("tmo_cnt", 32'(fcnt_o), 32'(exp_cnt));
            last = w;
         end else begin
            len = (mode == M_TERM) ? TO : $urandom_range(1, 40);
            for (int j = 1; j < len; j++) begin
               tick();
               if (j == 1) check("start_once", 32'(bus.o_tx_start), 32'd0);
            end
            bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
            bus.i_tx_busy = 1'b0;
            exp_cnt = exp_cnt + 16'd1;
            last    = w;
            check("done_cnt", 32'(fcnt_o), 32'(exp_cnt));
            check("done_idle", 32'(busy_o), 32'd0);
            check("done_noabort", 32'(bus.o_tx_abort), 32'd0);
            if (mode == M_ENOFF) begin
               add_req($urandom_range(0, NR - 1));
               drive_req();
               for (int j = 0; j < 3; j++) begin
                  tick();
                  check("enoff_ready", 32'(bus.o_req_ready), 32'd0);
               end
               check("enoff_idle", 32'(busy_o), 32'd0);
               enable = 1'b1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
